// File: rtl/trp_wbuf.sv
// Write-side buffer between the transpose engine and the shared buffer write port.
// Optional same-cycle bypass when the FIFO is empty: define TRP_WBUF_BYPASS_EN.
module trp_wbuf #(
  parameter int AW    = 16,
  parameter int BUFFD = 64,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init_pulse,
  input  logic [CNTW-1:0]      wr_total,
  input  logic [AW-1:0]        in_waddr,
  input  logic [BUFFD*8-1:0]   in_wdata,
  input  logic                 in_wvld,
  output logic [AW-1:0]        mem_waddr,
  output logic [BUFFD*8-1:0]   mem_wdata,
  output logic                 mem_wvld,
  input  logic                 mem_wrdy,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf_err,
  output logic [CNTW-1:0]      wr_cnt
);

  localparam int DW = BUFFD * 8;
  localparam int EW = AW + DW;
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [EW-1:0]   fifo_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]     occ_q, occ_d;
  logic [CNTW-1:0] total_q, total_d, in_cnt_q, in_cnt_d, wr_cnt_q, wr_cnt_d;
  logic            ovf_q, ovf_d;

  logic            fifo_empty, fifo_full, accept, fifo_push, fifo_pop, mem_hs;
  logic [EW-1:0]   head, port_entry;

  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_FULL);
  assign accept     = (state_q == S_RUN) && in_wvld && !init_pulse && (in_cnt_q != total_q);
  assign head       = fifo_q[rd_ptr_q];

`ifdef TRP_WBUF_BYPASS_EN
  // Bypass is held off in the first RUN cycle so a restart never shows a beat immediately.
  logic init_q, init_d, bypass;
  assign bypass    = accept && fifo_empty && !init_q;
  assign mem_wvld  = !fifo_empty || bypass;
  assign fifo_pop  = !fifo_empty && mem_wrdy;
  assign mem_hs    = mem_wvld && mem_wrdy;
  assign fifo_push = accept && !(bypass && mem_wrdy) && (!fifo_full || fifo_pop);

  always_comb begin
    port_entry = '0;
    if (bypass)
      port_entry = {in_waddr, in_wdata};
    else if (!fifo_empty)
      port_entry = head;
  end
`else
  assign mem_wvld  = !fifo_empty;
  assign fifo_pop  = !fifo_empty && mem_wrdy;
  assign mem_hs    = fifo_pop;
  assign fifo_push = accept && (!fifo_full || fifo_pop);

  always_comb begin
    port_entry = '0;
    if (!fifo_empty)
      port_entry = head;
  end
`endif

  assign mem_waddr = port_entry[EW-1:DW];
  assign mem_wdata = port_entry[DW-1:0];
  assign ovf_err   = ovf_q;
  assign wr_cnt    = wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_RUN:   if (in_cnt_q == total_q) state_d = S_DRAIN;
      S_DRAIN: if (fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (init_pulse)
      state_d = S_RUN;
  end

  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    done = (state_q == S_DONE);
  end

  // A dropped beat still advances in_cnt so an overflowing job terminates.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    total_d  = total_q;
    in_cnt_d = in_cnt_q;
    wr_cnt_d = wr_cnt_q;
    ovf_d    = ovf_q;
`ifdef TRP_WBUF_BYPASS_EN
    init_d   = init_pulse;
`endif
    if (init_pulse) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      total_d  = wr_total;
      in_cnt_d = '0;
      wr_cnt_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (fifo_push && !fifo_pop)
        occ_d = occ_q + 1'b1;
      else if (!fifo_push && fifo_pop)
        occ_d = occ_q - 1'b1;
      if (accept) in_cnt_d = in_cnt_q + 1'b1;
      if (accept && fifo_full && !fifo_pop) ovf_d = 1'b1;
      if (mem_hs && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      total_q  <= '0;
      in_cnt_q <= '0;
      wr_cnt_q <= '0;
      ovf_q    <= 1'b0;
`ifdef TRP_WBUF_BYPASS_EN
      init_q   <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      total_q  <= total_d;
      in_cnt_q <= in_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      ovf_q    <= ovf_d;
`ifdef TRP_WBUF_BYPASS_EN
      init_q   <= init_d;
`endif
    end
  end

  // Storage carries no reset; contents are only visible behind a nonzero occupancy.
  always_ff @(posedge clk) begin
    if (fifo_push)
      fifo_q[wr_ptr_q] <= {in_waddr, in_wdata};
  end

endmodule
